// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
// Irrigation plant controller: tank inlet valve (Ve), sprinkler pump (Bs),
// drip valve (Vs), alarm (Al) and level-sensor error (E).
// Field sensors are synchronised and debounced. A hysteretic fill FSM and an
// irrigation scheduler FSM (min/max run time, dead time between runs) then
// drive registered actuator outputs.
//
// Optional feature: define FILL_TIMEOUT_EN to build the fill timeout counter
// and the sticky fill_fault flag. Without it fill_fault is constant 0.
//
// Fill FSM
//   state    | meaning
//   FILL_OFF | inlet valve closed
//   FILL_ON  | inlet valve open, filling until H is seen
//
// Irrigation FSM
//   state    | meaning
//   IDLE     | waiting for soil demand with no alarm
//   SPRINKLE | pump running; method locked until the run ends
//   DRIP     | drip valve open; method locked until the run ends
//   GAP      | both actuators off for GAP_TICKS ticks
module irrigation_scheduler #(
   parameter int DEB_TICKS = 3,
   parameter int MIN_ON    = 10,
   parameter int MAX_ON    = 60,
   parameter int GAP_TICKS = 5,
   parameter int FILL_MAX  = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       H,
   input  logic       M,
   input  logic       L,
   input  logic       Ua,
   input  logic       Us,
   input  logic       T,
   output logic       Ve,
   output logic       Bs,
   output logic       Vs,
   output logic       Al,
   output logic       E,
   output logic [1:0] irr_state
);

   localparam int DW = $clog2(DEB_TICKS + 1);
   localparam int RW = $clog2(MAX_ON + 1);
   localparam int GW = $clog2(GAP_TICKS + 1);

   // Sensor bit positions inside the conditioned vectors
   localparam int S_L  = 0;
   localparam int S_M  = 1;
   localparam int S_H  = 2;
   localparam int S_US = 3;
   localparam int S_UA = 4;
   localparam int S_T  = 5;

   localparam logic [0:0] FILL_OFF = 1'b0;
   localparam logic [0:0] FILL_ON  = 1'b1;

   localparam logic [1:0] IRR_IDLE     = 2'd0;
   localparam logic [1:0] IRR_SPRINKLE = 2'd1;
   localparam logic [1:0] IRR_DRIP     = 2'd2;
   localparam logic [1:0] IRR_GAP      = 2'd3;

   logic [5:0]    sync1_q, sync1_d;
   logic [5:0]    sync2_q, sync2_d;
   logic [5:0]    filt_q, filt_d;
   logic [DW-1:0] deb_cnt_q [6];
   logic [DW-1:0] deb_cnt_d [6];
   logic          primed_q, primed_d;

   logic [0:0]    fill_st_q, fill_st_d;
   logic [1:0]    irr_st_q, irr_st_d;
   logic [RW-1:0] run_cnt_q, run_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;

   logic          ve_q, ve_d;
   logic          bs_q, bs_d;
   logic          vs_q, vs_d;
   logic          al_q, al_d;
   logic          e_q, e_d;

   logic          lvl_l, lvl_m, lvl_h, soil_wet, temp_hi;
   logic          level_err, empty, demand;
   logic          fill_fault, err, alarm;
   logic          run_done;

   // Air humidity is conditioned like the other sensors but does not steer
   // any decision yet.
   logic          unused_ua;
   assign unused_ua = filt_q[S_UA];

   // Two-flop synchroniser on the raw field sensors
   always_comb begin
      sync1_d = {T, Ua, Us, H, M, L};
      sync2_d = sync1_q;
   end

   // Priming load on the first tick, then per-sensor tick-based debounce
   always_comb begin
      filt_d   = filt_q;
      primed_d = primed_q;
      for (int i = 0; i < 6; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
      end
      if (tick) begin
         if (!primed_q) begin
            filt_d   = sync2_q;
            primed_d = 1'b1;
            for (int i = 0; i < 6; i++) begin
               deb_cnt_d[i] = '0;
            end
         end else begin
            for (int i = 0; i < 6; i++) begin
               if (sync2_q[i] != filt_q[i]) begin
                  // The tick that would bring the count to DEB_TICKS commits
                  if (deb_cnt_q[i] == DW'(DEB_TICKS - 1)) begin
                     filt_d[i]    = sync2_q[i];
                     deb_cnt_d[i] = '0;
                  end else begin
                     deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                  end
               end else begin
                  deb_cnt_d[i] = '0;
               end
            end
         end
      end
   end

   assign lvl_l    = filt_q[S_L];
   assign lvl_m    = filt_q[S_M];
   assign lvl_h    = filt_q[S_H];
   assign soil_wet = filt_q[S_US];
   assign temp_hi  = filt_q[S_T];

   assign level_err = (lvl_m & ~lvl_l) | (lvl_h & ~lvl_m);
   assign empty     = ~lvl_l & ~level_err;
   assign demand    = ~soil_wet;
   assign err       = level_err | fill_fault;
   assign alarm     = err | empty;

`ifdef FILL_TIMEOUT_EN
   localparam int FW = $clog2(FILL_MAX + 1);

   logic [FW-1:0] fill_cnt_q, fill_cnt_d;
   logic          fill_fault_q, fill_fault_d;

   // Fault is visible in the same cycle the counter hits its limit, so the
   // valve closes together with E/Al rising.
   assign fill_fault = fill_fault_q | (fill_cnt_q == FW'(FILL_MAX));

   // Fill duration counter, alive only while the fill FSM stays ON
   always_comb begin
      fill_cnt_d   = '0;
      fill_fault_d = fill_fault;
      if (fill_st_q == FILL_ON && fill_st_d == FILL_ON) begin
         fill_cnt_d = fill_cnt_q;
         if (tick && fill_cnt_q != FW'(FILL_MAX)) begin
            fill_cnt_d = fill_cnt_q + FW'(1);
         end
      end
   end

   // Fill timeout registers; the fault is sticky until reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_cnt_q   <= '0;
         fill_fault_q <= 1'b0;
      end else begin
         fill_cnt_q   <= fill_cnt_d;
         fill_fault_q <= fill_fault_d;
      end
   end
`else
   logic unused_fill_max;
   assign unused_fill_max = (FILL_MAX != 0);
   assign fill_fault      = 1'b0;
`endif

   // Hysteretic tank fill: start below M, stop at H or on any level fault
   always_comb begin
      fill_st_d = fill_st_q;
      if (!primed_q) begin
         fill_st_d = FILL_OFF;
      end else begin
         case (fill_st_q)
            FILL_OFF: if (!lvl_m && !alarm) fill_st_d = FILL_ON;
            default:  if (lvl_h || level_err || fill_fault) fill_st_d = FILL_OFF;
         endcase
      end
   end

   assign run_done = alarm
                   | (~demand & (run_cnt_q >= RW'(MIN_ON)))
                   | (run_cnt_q == RW'(MAX_ON));

   // Irrigation scheduler: method chosen at run start and held until GAP
   always_comb begin
      irr_st_d  = irr_st_q;
      run_cnt_d = run_cnt_q;
      gap_cnt_d = gap_cnt_q;
      if (!primed_q) begin
         irr_st_d  = IRR_IDLE;
         run_cnt_d = '0;
         gap_cnt_d = '0;
      end else begin
         case (irr_st_q)
            IRR_IDLE: begin
               if (demand && !alarm) begin
                  irr_st_d  = (temp_hi || !lvl_m) ? IRR_DRIP : IRR_SPRINKLE;
                  run_cnt_d = '0;
               end
            end
            IRR_SPRINKLE, IRR_DRIP: begin
               if (run_done) begin
                  irr_st_d  = IRR_GAP;
                  gap_cnt_d = '0;
               end else if (tick && run_cnt_q != RW'(MAX_ON)) begin
                  run_cnt_d = run_cnt_q + RW'(1);
               end
            end
            default: begin
               if (gap_cnt_q == GW'(GAP_TICKS)) begin
                  irr_st_d  = IRR_IDLE;
                  gap_cnt_d = '0;
               end else if (tick) begin
                  gap_cnt_d = gap_cnt_q + GW'(1);
               end
            end
         endcase
      end
   end

   // Outputs decoded from next state so alarms and actuators move together
   always_comb begin
      ve_d = primed_q & (fill_st_d == FILL_ON);
      bs_d = primed_q & (irr_st_d == IRR_SPRINKLE);
      vs_d = primed_q & (irr_st_d == IRR_DRIP);
      al_d = primed_q & alarm;
      e_d  = primed_q & err;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         filt_q    <= '0;
         primed_q  <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            deb_cnt_q[i] <= '0;
         end
         fill_st_q <= FILL_OFF;
         irr_st_q  <= IRR_IDLE;
         run_cnt_q <= '0;
         gap_cnt_q <= '0;
         ve_q      <= 1'b0;
         bs_q      <= 1'b0;
         vs_q      <= 1'b0;
         al_q      <= 1'b0;
         e_q       <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         filt_q    <= filt_d;
         primed_q  <= primed_d;
         for (int i = 0; i < 6; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
         fill_st_q <= fill_st_d;
         irr_st_q  <= irr_st_d;
         run_cnt_q <= run_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ve_q      <= ve_d;
         bs_q      <= bs_d;
         vs_q      <= vs_d;
         al_q      <= al_d;
         e_q       <= e_d;
      end
   end

   assign Ve        = ve_q;
   assign Bs        = bs_q;
   assign Vs        = vs_q;
   assign Al        = al_q;
   assign E         = e_q;
   assign irr_state = irr_st_q;

endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

- Sequential controller for the irrigation plant: the tank inlet valve, the sprinkler pump and the drip valve, with alarm and error flags.
- Synchronises and debounces the six field sensors, then runs two FSMs:
  - a hysteretic tank-fill controller;
  - an irrigation scheduler that enforces minimum/maximum run times and a dead time between runs.
- Outputs drive the actuators directly and replace the purely combinational decode used today.

## Interface
- DEB_TICKS, 3: consecutive ticks a synchronised sensor must hold a new value before the filtered copy updates (≥1).
- MIN_ON, 10: minimum irrigation run length in ticks (≥1).
- MAX_ON, 60: maximum irrigation run length in ticks (>MIN_ON).
- GAP_TICKS, 5: dead time after a run with both irrigation actuators off (≥1).
- FILL_MAX, 120: fill timeout in ticks (used only with FILL_TIMEOUT_EN).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- tick  in  1  single-cycle time-base strobe; all timers advance only on tick.
- H, M, L  in  1 each  tank level sensors, high/medium/low; 1 = water at that level.
- Ua  in  1  air humidity high.
- Us  in  1  soil wet.
- T  in  1  temperature high.
- Ve  out  1  inlet valve open.
- Bs  out  1  sprinkler pump on.
- Vs  out  1  drip valve open.
- Al  out  1  alarm.
- E  out  1  level-sensor error.
- irr_state  out  2  scheduler state: 0 IDLE, 1 SPRINKLE, 2 DRIP, 3 GAP.

## Operation
- **Input conditioning**
  - Each sensor passes a 2-flop synchroniser, then a per-sensor debounce counter.
  - On each tick, if the synced value differs from the filtered value, the counter increments. Otherwise it clears.
  - When the counter reaches DEB_TICKS, the filtered value takes the synced value and the counter clears.
- **Priming**
  - A `primed` flag resets to 0.
  - On the first tick after reset, all filtered regs load the synced inputs directly and `primed` sets.
  - While `primed`=0: all outputs are 0 and both FSMs are held idle.
- **Derived conditions** (from filtered values):
  - level_err = (M & !L) | (H & !M).
  - empty = !L & !level_err.
  - demand = !Us.
- **Error and alarm**
  - E = level_err | fill_fault.
  - Al = E | empty.
- **Fill FSM** (OFF/ON)
  - OFF→ON when !M & !Al.
  - ON→OFF when H | level_err | fill_fault.
  - Ve = 1 in ON only.
  - The band between M and H gives hysteresis: fill never restarts until the level drops below M.
- **Irrigation FSM**
  - IDLE→DRIP when demand & !Al & (T | !M).
  - IDLE→SPRINKLE when demand & !Al & !(T | !M).
  - The method is locked for the whole run. Entering a run clears run_cnt.
  - SPRINKLE/DRIP: run_cnt increments per tick.
  - SPRINKLE/DRIP→GAP on the first of:
    - Al (immediate, ignores MIN_ON);
    - !demand with run_cnt ≥ MIN_ON;
    - run_cnt = MAX_ON.
  - GAP: counts GAP_TICKS ticks, then returns to IDLE. A new run cannot start from GAP.
  - Bs = 1 only in SPRINKLE; Vs = 1 only in DRIP. Bs & Vs is never 1.
- Filling and irrigating may be active simultaneously.
- Counters saturate and never wrap.
- Reset asserted mid-run, mid-fill or mid-gap returns everything to the reset state on the next edge.

## Timing
- Reset values: Ve=Bs=Vs=Al=E=0, irr_state=0, all counters 0, filtered regs 0, fill_fault=0.
- All outputs are registered.
- Latency:
  - Filtered-value change → outputs updated 1 clk later.
  - Raw input change → filtered update after 2 clk sync plus DEB_TICKS ticks.
- Run length:
  - A run started on tick n with demand still present lasts exactly MAX_ON ticks.
  - If demand clears early, the run lasts exactly max(MIN_ON, ticks until demand clears).
- Al assertion turns off Bs/Vs and Ve (if the Al cause is level_err or fill_fault) in the same clk that Al rises.
- tick held high for several clocks counts once per clk; the source must pulse it.

## Configuration
- FILL_TIMEOUT_EN defined:
  - A fill counter runs on each tick while the fill FSM is ON and clears on leaving ON.
  - When the counter reaches FILL_MAX, sticky fill_fault sets and forces the fill FSM to OFF, E=1 and Al=1.
  - fill_fault clears only on reset.
- FILL_TIMEOUT_EN undefined:
  - No fill counter is built; fill_fault is constant 0.
  - FILL_MAX is ignored.

## Test plan
- Reset with L=M=H=0, then release: all outputs 0 until the first tick. After priming, Al=1, E=0, Ve=0 (tank empty) and irr_state=0.
- L=M=1, H=0, Us=0, T=0: → SPRINKLE, Bs=1. Us=1 applied at run tick 4 (debounced) → Bs holds until tick 10 (MIN_ON), then GAP for 5 ticks, then IDLE.
- L=1, M=0, Us=0: → Ve=1 and DRIP (Vs=1) together. Hold Us=0 → Vs drops after exactly 60 ticks. Raise M then H → Ve closes only when H is filtered high.
- During SPRINKLE, apply H=1, M=0: level_err → E=1, Al=1, Bs=0 and state=GAP in the same clk. Glitch on M shorter than DEB_TICKS → no change.
- With FILL_TIMEOUT_EN, L=1, M=H=0 held: Ve=1 for 120 ticks, then Ve=0, E=1, Al=1, latched. Raising H does not clear it; rst_n low clears it.
- Assert rst_n=0 mid-DRIP at run tick 7: next clk Vs=0, irr_state=0, counters 0.
